// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: sequences EX load/store requests onto the data memory for LATENCY cycles,
// stalls upstream while busy and returns registered load data. Optional: DUMP_ON_HALT_EN.
module mem_req_ctrl #(
    parameter int LATENCY     = 1,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_en,
    input  logic        ex_mem_wr,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_wdata,
    input  logic        ex_halt,
    input  logic        flush,
    input  logic [15:0] mem_rdata,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_createdump,
    output logic        stall,
    output logic        wb_valid,
    output logic [15:0] wb_rdata,
    output logic        err
);

    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1
`ifdef DUMP_ON_HALT_EN
        ,
        HALTED = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic             wb_valid_q, wb_valid_d;
    logic [15:0]      wb_rdata_q, wb_rdata_d;
    logic             err_q, err_d;

    logic new_req;
    logic misaligned;
    logic last;

    assign new_req    = ex_valid & ex_mem_en & ~flush;
    assign misaligned = (CHECK_ALIGN != 0) && ex_addr[0];
    assign last       = (cnt_q == '0);

`ifdef DUMP_ON_HALT_EN
    logic dump_q, dump_d;
    logic halt_req;

    assign halt_req       = ex_valid & ex_halt & ~flush;
    assign mem_createdump = dump_q;
`else
    logic unused_halt;

    assign unused_halt    = ex_halt;
    assign mem_createdump = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        wb_valid_d = 1'b0;
        wb_rdata_d = wb_rdata_q;
        err_d      = err_q;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        stall      = 1'b0;
`ifdef DUMP_ON_HALT_EN
        dump_d     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                stall = new_req;
                if (new_req) begin
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    wr_d    = ex_mem_wr;
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_LAST;
                    end
                end
`ifdef DUMP_ON_HALT_EN
                else if (halt_req) begin
                    state_d = HALTED;
                    dump_d  = 1'b1;
                end
`endif
            end

            ACCESS: begin
                mem_enable = 1'b1;
                mem_wr     = wr_q & last;
                stall      = ~last;
                if (!last) begin
                    // A flush before the final cycle drops loads and stores alike.
                    if (flush) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    // Final cycle: a store commits even under flush; a flushed load returns nothing.
                    state_d = IDLE;
                    if (!wr_q && !flush) begin
                        wb_valid_d = 1'b1;
                        wb_rdata_d = mem_rdata;
                    end
                end
            end

`ifdef DUMP_ON_HALT_EN
            HALTED: begin
                stall = 1'b1;
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            mem_enable = 1'b0;
            mem_wr     = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            wb_valid_q <= wb_valid_d;
            wb_rdata_q <= wb_rdata_d;
            err_q      <= err_d;
        end
    end

`ifdef DUMP_ON_HALT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_q <= 1'b0;
        end else begin
            dump_q <= dump_d;
        end
    end
`endif

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rdata  = wb_rdata_q;
    assign err       = err_q;

endmodule
